// File: rtl/rf_alu_ctrl_seq.sv
// rf_alu_ctrl_seq: multi-cycle instruction sequencer for the control side of RF_ALU.
//
// Accepts 16-bit instructions over a valid/ready handshake, decodes them and drives
// the RF_ALU control strobes. Conditional branches test the C/V/N/Z flags that were
// latched on the most recent ALU-reg/ADDI/SUBI/CMP cycle. Loads and stores hold the
// address controls while waiting for mem_ack, with a bus-error timeout.
//
// Handshake: an instruction transfers on a rising CLK edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only in FETCH. instr_valid in any other
// state is ignored, and instr may change freely while instr_ready is 0.
//
// Ports:
//   CLK, CLR            clock, synchronous active-high reset
//   instr, instr_valid  instruction word and its valid qualifier
//   instr_ready         sequencer takes instr this cycle
//   C, V, N, Z          RF_ALU flags for the current cycle
//   mem_ack             memory completes the current request
//   ALUctrl, ALUsrc     ALU operation, B-operand select (1 = imm5)
//   RdAddr/RnAddr/RmAddr, imm8, imm5  decoded fields (0 outside EXEC/MEM)
//   MOV, ALU2Rd, LHI, LLI, MemoryW, PCW, WE, S_Rn_or_Rd  RF_ALU write controls
//   mem_rd_req, mem_wr_req  memory request strobes
//   branch_taken        one-cycle pulse, imm8 is the offset
//   halted, illegal, mem_err  status (illegal and mem_err are sticky)
//   dbg_state           current FSM state
module rf_alu_ctrl_seq #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        C,
  input  logic        V,
  input  logic        N,
  input  logic        Z,
  input  logic        mem_ack,
  output logic [1:0]  ALUctrl,
  output logic        ALUsrc,
  output logic [2:0]  RdAddr,
  output logic [2:0]  RnAddr,
  output logic [2:0]  RmAddr,
  output logic [7:0]  imm8,
  output logic [4:0]  imm5,
  output logic        MOV,
  output logic        ALU2Rd,
  output logic        LHI,
  output logic        LLI,
  output logic        MemoryW,
  output logic        PCW,
  output logic        WE,
  output logic        S_Rn_or_Rd,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic        branch_taken,
  output logic        halted,
  output logic        illegal,
  output logic        mem_err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00001;
  localparam logic [4:0] OP_SUBI = 5'b00010;
  localparam logic [4:0] OP_MOV  = 5'b00011;
  localparam logic [4:0] OP_LHI  = 5'b00100;
  localparam logic [4:0] OP_LLI  = 5'b00101;
  localparam logic [4:0] OP_LDR  = 5'b00110;
  localparam logic [4:0] OP_STR  = 5'b00111;
  localparam logic [4:0] OP_JAL  = 5'b01000;
  localparam logic [4:0] OP_CMP  = 5'b01001;
  localparam logic [4:0] OP_BCC  = 5'b01010;
  localparam logic [4:0] OP_HLT  = 5'b01111;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [15:0] r_ir;
  logic [3:0]  r_flags;   // {C, V, N, Z}
  logic [7:0]  r_cnt;
  logic        r_illegal;
  logic        r_mem_err;

  logic [4:0]  w_op;
  logic [2:0]  w_cond;
  logic        w_cond_true;
  logic        w_is_str;

  assign w_op     = r_ir[15:11];
  assign w_cond   = r_ir[10:8];
  // LDR and STR differ only in the opcode LSB; in MEM the IR holds one of the two.
  assign w_is_str = r_ir[11];

  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      3'b000: w_cond_true = r_flags[0];
      3'b001: w_cond_true = ~r_flags[0];
      3'b010: w_cond_true = r_flags[3];
      3'b011: w_cond_true = ~r_flags[3];
      3'b100: w_cond_true = r_flags[1];
      3'b101: w_cond_true = ~r_flags[1];
      3'b110: w_cond_true = r_flags[2];
      default: w_cond_true = 1'b1;
    endcase
  end

  always_comb begin
    instr_ready  = 1'b0;
    ALUctrl      = 2'b00;
    ALUsrc       = 1'b0;
    RdAddr       = 3'd0;
    RnAddr       = 3'd0;
    RmAddr       = 3'd0;
    imm8         = 8'd0;
    imm5         = 5'd0;
    MOV          = 1'b0;
    ALU2Rd       = 1'b0;
    LHI          = 1'b0;
    LLI          = 1'b0;
    MemoryW      = 1'b0;
    PCW          = 1'b0;
    WE           = 1'b0;
    S_Rn_or_Rd   = 1'b0;
    mem_rd_req   = 1'b0;
    mem_wr_req   = 1'b0;
    branch_taken = 1'b0;
    halted       = 1'b0;
    case (r_state)
      ST_FETCH: instr_ready = 1'b1;
      ST_EXEC: begin
        RdAddr = r_ir[10:8];
        RnAddr = r_ir[7:5];
        RmAddr = r_ir[4:2];
        imm8   = r_ir[7:0];
        imm5   = r_ir[4:0];
        case (w_op)
          OP_ALU:  begin ALUctrl = r_ir[1:0]; ALU2Rd = 1'b1; WE = 1'b1; end
          OP_ADDI: begin ALUsrc = 1'b1; ALU2Rd = 1'b1; WE = 1'b1; end
          OP_SUBI: begin ALUctrl = 2'b10; ALUsrc = 1'b1; ALU2Rd = 1'b1; WE = 1'b1; end
          OP_MOV:  begin MOV = 1'b1; WE = 1'b1; end
          OP_LHI:  begin LHI = 1'b1; S_Rn_or_Rd = 1'b1; WE = 1'b1; end
          OP_LLI:  begin LLI = 1'b1; S_Rn_or_Rd = 1'b1; WE = 1'b1; end
          OP_JAL:  begin PCW = 1'b1; WE = 1'b1; end
          OP_CMP:  ALUctrl = 2'b10;
          OP_BCC:  branch_taken = w_cond_true;
          OP_LDR:  ALUsrc = 1'b1;
          OP_STR:  begin ALUsrc = 1'b1; S_Rn_or_Rd = 1'b1; end
          default: ;
        endcase
      end
      ST_MEM: begin
        RdAddr     = r_ir[10:8];
        RnAddr     = r_ir[7:5];
        RmAddr     = r_ir[4:2];
        imm8       = r_ir[7:0];
        imm5       = r_ir[4:0];
        ALUsrc     = 1'b1;
        S_Rn_or_Rd = w_is_str;
        mem_wr_req = w_is_str;
        mem_rd_req = ~w_is_str;
        // Load write-back happens in the ack cycle while Memory_data is valid.
        MemoryW    = mem_ack & ~w_is_str;
        WE         = mem_ack & ~w_is_str;
      end
      default: halted = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state   <= ST_FETCH;
      r_ir      <= 16'd0;
      r_flags   <= 4'd0;
      r_cnt     <= 8'd0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (w_op)
            OP_ALU, OP_ADDI, OP_SUBI, OP_CMP: begin
              r_flags <= {C, V, N, Z};
              r_state <= ST_FETCH;
            end
            OP_MOV, OP_LHI, OP_LLI, OP_JAL, OP_BCC: r_state <= ST_FETCH;
            OP_LDR, OP_STR: begin
              r_cnt   <= 8'd0;
              r_state <= ST_MEM;
            end
            OP_HLT: r_state <= ST_HALT;
            default: begin
              r_illegal <= 1'b1;
              r_state   <= ST_HALT;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            r_cnt   <= 8'd0;
            r_state <= ST_FETCH;
          end else if (r_cnt == TIMEOUT_LAST) begin
            // This is the MEM_TIMEOUT-th cycle without an ack.
            r_cnt     <= 8'd0;
            r_mem_err <= 1'b1;
            r_state   <= ST_HALT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign illegal   = r_illegal;
  assign mem_err   = r_mem_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rf_alu_ctrl_seq.sv
// Bench for rf_alu_ctrl_seq: table of single-cycle instructions checked through an
// expected-value queue, plus hand-written load/store/halt/reset sequences.
module tb_rf_alu_ctrl_seq;

  localparam int W = 36;
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Strobe vector bit order: MOV ALU2Rd LHI LLI MemoryW PCW WE S_Rn_or_Rd branch rd_req wr_req
  localparam logic [10:0] S_MOV = 11'b100_0000_0000;
  localparam logic [10:0] S_A2R = 11'b010_0000_0000;
  localparam logic [10:0] S_LHI = 11'b001_0000_0000;
  localparam logic [10:0] S_LLI = 11'b000_1000_0000;
  localparam logic [10:0] S_PCW = 11'b000_0010_0000;
  localparam logic [10:0] S_WE  = 11'b000_0001_0000;
  localparam logic [10:0] S_SRN = 11'b000_0000_1000;
  localparam logic [10:0] S_BR  = 11'b000_0000_0100;
  localparam logic [10:0] S_NONE = 11'b000_0000_0000;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic [15:0] instr = 16'd0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        C = 1'b0, V = 1'b0, N = 1'b0, Z = 1'b0;
  logic        mem_ack = 1'b0;
  logic [1:0]  ALUctrl;
  logic        ALUsrc;
  logic [2:0]  RdAddr, RnAddr, RmAddr;
  logic [7:0]  imm8;
  logic [4:0]  imm5;
  logic        MOV, ALU2Rd, LHI, LLI, MemoryW, PCW, WE, S_Rn_or_Rd;
  logic        mem_rd_req, mem_wr_req, branch_taken, halted, illegal, mem_err;
  logic [1:0]  dbg_state;

  rf_alu_ctrl_seq #(.MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .CLR(CLR), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .C(C), .V(V), .N(N), .Z(Z), .mem_ack(mem_ack),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .RdAddr(RdAddr), .RnAddr(RnAddr),
    .RmAddr(RmAddr), .imm8(imm8), .imm5(imm5), .MOV(MOV), .ALU2Rd(ALU2Rd),
    .LHI(LHI), .LLI(LLI), .MemoryW(MemoryW), .PCW(PCW), .WE(WE),
    .S_Rn_or_Rd(S_Rn_or_Rd), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .branch_taken(branch_taken), .halted(halted), .illegal(illegal),
    .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  flags;     // {C, V, N, Z} presented during EXEC
    logic [1:0]  alu_ctrl;
    logic        alu_src;
    logic [10:0] strb;
  } vec_t;

  vec_t vecs[18];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_out();
    return {ALUctrl, ALUsrc, RdAddr, RnAddr, RmAddr, imm8, imm5,
            MOV, ALU2Rd, LHI, LLI, MemoryW, PCW, WE, S_Rn_or_Rd,
            branch_taken, mem_rd_req, mem_wr_req};
  endfunction

  // Driver: present one instruction in FETCH; returns in the EXEC cycle.
  task automatic send(input logic [15:0] word);
    chk("fetch_ready", int'(word), 64'(instr_ready), 64'd1);
    instr       = word;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr       = 16'($urandom_range(0, 65535));
  endtask

  task automatic do_reset(input int cycles);
    CLR = 1'b1;
    for (int k = 0; k < cycles; k++) step();
    CLR = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_w;
    int           n_req;
    logic         bad_wr;

    vecs[0]  = '{16'h0105, 4'b0000, 2'b01, 1'b0, S_A2R | S_WE};
    vecs[1]  = '{16'h0A67, 4'b1000, 2'b00, 1'b1, S_A2R | S_WE};    // ADDI, C=1
    vecs[2]  = '{16'h5212, 4'b0000, 2'b00, 1'b0, S_BR};            // B C
    vecs[3]  = '{16'h5334, 4'b0000, 2'b00, 1'b0, S_NONE};          // B !C
    vecs[4]  = '{16'h4828, 4'b0001, 2'b10, 1'b0, S_NONE};          // CMP, Z=1
    vecs[5]  = '{16'h50F0, 4'b0000, 2'b00, 1'b0, S_BR};            // B Z
    vecs[6]  = '{16'h51F0, 4'b0000, 2'b00, 1'b0, S_NONE};          // B !Z
    vecs[7]  = '{16'h15DF, 4'b0110, 2'b10, 1'b1, S_A2R | S_WE};    // SUBI, V=N=1
    vecs[8]  = '{16'h5455, 4'b0000, 2'b00, 1'b0, S_BR};            // B N
    vecs[9]  = '{16'h5666, 4'b0000, 2'b00, 1'b0, S_BR};            // B V
    vecs[10] = '{16'h5577, 4'b0000, 2'b00, 1'b0, S_NONE};          // B !N
    vecs[11] = '{16'h1B80, 4'b0000, 2'b00, 1'b0, S_MOV | S_WE};
    vecs[12] = '{16'h26AA, 4'b0000, 2'b00, 1'b0, S_LHI | S_SRN | S_WE};
    vecs[13] = '{16'h2955, 4'b0000, 2'b00, 1'b0, S_LLI | S_SRN | S_WE};
    vecs[14] = '{16'h4703, 4'b0000, 2'b00, 1'b0, S_PCW | S_WE};    // JAL
    vecs[15] = '{16'h57AB, 4'b0000, 2'b00, 1'b0, S_BR};            // B always
    vecs[16] = '{16'h1B80, 4'b0001, 2'b00, 1'b0, S_MOV | S_WE};    // MOV must not latch Z
    vecs[17] = '{16'h5000, 4'b0000, 2'b00, 1'b0, S_NONE};          // B Z, still 0

    // Power-on reset state
    do_reset(2);
    chk("rst_state", 0, 64'(dbg_state), 64'(ST_FETCH));
    chk("rst_outs", 0, 64'(pack_out()), 64'd0);
    chk("rst_sticky", 0, 64'({illegal, mem_err, halted}), 64'd0);

    // Reset held 2 cycles during a MEM wait
    send(16'h3264);
    step();
    chk("mem_pre_rst", 0, 64'(mem_rd_req), 64'd1);
    step();
    do_reset(2);
    chk("midmem_state", 0, 64'(dbg_state), 64'(ST_FETCH));
    chk("midmem_flags", 0, 64'({instr_ready, mem_rd_req, WE, illegal, mem_err}),
        64'b10000);

    // Table-driven single-cycle instructions through the expected queue
    for (int i = 0; i < 18; i++) begin
      exp_w = {vecs[i].alu_ctrl, vecs[i].alu_src, vecs[i].instr[10:8],
               vecs[i].instr[7:5], vecs[i].instr[4:2], vecs[i].instr[7:0],
               vecs[i].instr[4:0], vecs[i].strb};
      exp_q.push_back(exp_w);
      send(vecs[i].instr);
      {C, V, N, Z} = vecs[i].flags;
      chk("exec", i, 64'(pack_out()), 64'(exp_q.pop_front()));
      step();
      {C, V, N, Z} = 4'b0000;
      chk("post_idle", i, 64'({instr_ready, pack_out()}), 64'({1'b1, 36'd0}));
    end

    // LDR Rd=2 Rn=3 imm5=4, ack after 3 wait cycles
    send(16'h3264);
    chk("ldr_exec", 0, 64'({ALUctrl, ALUsrc, imm5, mem_rd_req, WE}),
        64'({2'b00, 1'b1, 5'd4, 1'b0, 1'b0}));
    step();
    n_req = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ack = (k == 3);
      #1;
      if (mem_rd_req) n_req++;
      chk("ldr_mem", k, 64'({mem_rd_req, mem_wr_req, ALUsrc, imm5, RdAddr, MemoryW, WE}),
          64'({1'b1, 1'b0, 1'b1, 5'd4, 3'd2, mem_ack, mem_ack}));
      step();
    end
    mem_ack = 1'b0;
    chk("ldr_req_cycles", 0, 64'(n_req), 64'd4);
    chk("ldr_done", 0, 64'({instr_ready, mem_rd_req, WE, MemoryW}), 64'b1000);

    // STR with no ack: timeout into HALT
    send(16'h3D22);
    chk("str_exec", 0, 64'({ALUsrc, S_Rn_or_Rd, mem_wr_req}), 64'b110);
    step();
    n_req  = 0;
    bad_wr = 1'b0;
    for (int k = 0; k < 40 && !halted; k++) begin
      if (mem_wr_req) n_req++;
      if (WE || MemoryW) bad_wr = 1'b1;
      step();
    end
    chk("str_halted", 0, 64'(halted), 64'd1);
    chk("str_req_cycles", 0, 64'(n_req), 64'd15);
    chk("str_mem_err", 0, 64'(mem_err), 64'd1);
    chk("str_no_write", 0, 64'(bad_wr), 64'd0);
    instr       = 16'h0105;
    instr_valid = 1'b1;
    step();
    step();
    chk("halt_ignores", 0, 64'({dbg_state, instr_ready, WE, halted}),
        64'({ST_HALT, 1'b0, 1'b0, 1'b1}));
    instr_valid = 1'b0;
    do_reset(1);
    chk("err_cleared", 0, 64'({mem_err, halted, instr_ready}), 64'b001);

    // Undefined opcode
    send(16'hF800);
    chk("ill_exec", 0, 64'(pack_out()), 64'd0);
    step();
    chk("ill_status", 0, 64'({illegal, halted, instr_ready, WE, MemoryW, PCW}),
        64'b110000);
    do_reset(1);
    chk("ill_cleared", 0, 64'({illegal, halted}), 64'b00);

    // HLT: halts without flagging illegal
    send(16'h7800);
    step();
    chk("hlt_status", 0, 64'({illegal, halted, mem_err}), 64'b010);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL queue_left actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
